requestor_rr_arbiter: RTL and testbench

- N-way round-robin request arbiter directly upstream of the requestor-vector stage's memory port.
- Collects per-requestor valid/ready request channels and drives one registered memory request channel that carries the winner's tag.
- Supports locked bursts: a requestor holding `lock` keeps the grant until it sends a beat with lock clear.
- One-entry registered output stage gives full throughput without a combinational path from mem ready to requestor ready beyond one mux level.

---
 rtl/requestor_rr_arbiter_pkg.sv | 18 +
 rtl/requestor_rr_arbiter_pick.sv | 33 +++
 rtl/requestor_rr_arbiter.sv | 112 +++++++++++
 tb/tb_requestor_rr_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/requestor_rr_arbiter_pkg.sv
// Shared constants and types for the round-robin request arbiter.
package requestor_rr_arbiter_pkg;

  localparam int N_REQ_DEFAULT  = 4;
  localparam int DATA_W_DEFAULT = 32;
  localparam int TAG_W_DEFAULT  = $clog2(N_REQ_DEFAULT);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [DATA_W_DEFAULT-1:0] data;
    logic                      lock;
  } req_bundle_t;

endpackage

// File: rtl/requestor_rr_arbiter_pick.sv
// Combinational first-valid search starting at start_i and wrapping modulo N.
// Zero latency; found_o low when no input is valid.
module rr_priority_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     valid_i,
  input  logic [IDX_W-1:0] start_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [2*N-1:0] rotated;
  logic [IDX_W:0] sum;

  // Doubling the vector turns the wrapped search into a plain right shift.
  assign rotated = {valid_i, valid_i} >> start_i;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    sum     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        found_o = 1'b1;
        sum     = {1'b0, start_i} + (IDX_W+1)'(k);
        if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
        idx_o   = sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/requestor_rr_arbiter.sv
// N-way round-robin arbiter with locked bursts feeding a one-entry registered output stage.
// One cycle handshake-to-valid; no grant while the held beat is not accepted downstream.
module requestor_rr_arbiter
  import requestor_rr_arbiter_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int TAG_W  = $clog2(N_REQ)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             io_requestor_req_valid,
  output logic [N_REQ-1:0]             io_requestor_req_ready,
  input  logic [N_REQ-1:0][DATA_W-1:0] io_requestor_req_bits_data,
  input  logic [N_REQ-1:0]             io_requestor_req_bits_lock,
  output logic                         io_mem_req_valid,
  input  logic                         io_mem_req_ready,
  output logic [DATA_W-1:0]            io_mem_req_bits_data,
  output logic [TAG_W-1:0]             io_mem_req_bits_tag,
  output logic                         io_locked
);

  arb_state_e        state_q, state_d;
  logic [TAG_W-1:0]  owner_q, owner_d;
  logic [TAG_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              out_vld_q, out_vld_d;
  logic [DATA_W-1:0] out_dat_q, out_dat_d;
  logic [TAG_W-1:0]  out_tag_q, out_tag_d;

  logic [N_REQ-1:0]  eligible;
  logic [TAG_W-1:0]  start_idx;
  logic              found;
  logic [TAG_W-1:0]  win_idx;
  logic              slot_free;
  logic              grant;

  assign slot_free = !out_vld_q || io_mem_req_ready;
  assign start_idx = (rr_ptr_q == TAG_W'(N_REQ - 1)) ? '0 : rr_ptr_q + 1'b1;

  // While locked only the owner may compete; the search start is then irrelevant.
  always_comb begin
    eligible = io_requestor_req_valid;
    if (state_q == LOCKED) begin
      eligible = '0;
      eligible[owner_q] = io_requestor_req_valid[owner_q];
    end
  end

  rr_priority_pick #(
    .N     (N_REQ),
    .IDX_W (TAG_W)
  ) u_pick (
    .valid_i (eligible),
    .start_i (start_idx),
    .found_o (found),
    .idx_o   (win_idx)
  );

  assign grant = found && slot_free && !reset;

  always_comb begin
    io_requestor_req_ready = '0;
    io_requestor_req_ready[win_idx] = grant;
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    out_tag_d = out_tag_q;
    if (grant) begin
      out_vld_d = 1'b1;
      out_dat_d = io_requestor_req_bits_data[win_idx];
      out_tag_d = win_idx;
      rr_ptr_d  = win_idx;
      if (state_q == IDLE && io_requestor_req_bits_lock[win_idx]) begin
        state_d = LOCKED;
        owner_d = win_idx;
      end else if (state_q == LOCKED && !io_requestor_req_bits_lock[win_idx]) begin
        state_d = IDLE;
      end
    end else if (slot_free) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= TAG_W'(N_REQ - 1);
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      out_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
      out_tag_q <= out_tag_d;
    end
  end

  assign io_mem_req_valid     = out_vld_q;
  assign io_mem_req_bits_data = out_dat_q;
  assign io_mem_req_bits_tag  = out_tag_q;
  assign io_locked            = (state_q == LOCKED);

endmodule

// File: tb/tb_requestor_rr_arbiter.sv
// Scenario and randomized bench for requestor_rr_arbiter against a rule-level reference model.
module tb_requestor_rr_arbiter;

  localparam int N = 4;
  localparam int DW = 32;
  localparam int TW = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  logic [N-1:0][DW-1:0] req_data;
  logic [N-1:0]         req_lock;
  logic                 mem_valid;
  logic                 mem_ready;
  logic [DW-1:0]        mem_data;
  logic [TW-1:0]        mem_tag;
  logic                 locked;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: what the output register holds and who owns the lock.
  bit          m_vld = 0;
  logic [DW-1:0] m_data = '0;
  int          m_tag = 0;
  int          m_ptr = N - 1;
  bit          m_locked = 0;
  int          m_owner = 0;
  int          last_w;

  always #5 clk = ~clk;

  requestor_rr_arbiter #(.N_REQ(N), .DATA_W(DW), .TAG_W(TW)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .io_requestor_req_valid     (req_valid),
    .io_requestor_req_ready     (req_ready),
    .io_requestor_req_bits_data (req_data),
    .io_requestor_req_bits_lock (req_lock),
    .io_mem_req_valid           (mem_valid),
    .io_mem_req_ready           (mem_ready),
    .io_mem_req_bits_data       (mem_data),
    .io_mem_req_bits_tag        (mem_tag),
    .io_locked                  (locked)
  );

  function automatic int model_winner();
    if (reset) return -1;
    if (m_vld && !mem_ready) return -1;
    if (m_locked) return req_valid[m_owner] ? m_owner : -1;
    for (int k = 1; k <= N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_update(input int w);
    if (reset) begin
      m_vld = 0; m_data = '0; m_tag = 0; m_locked = 0; m_ptr = N - 1;
    end else if (w >= 0) begin
      m_vld = 1; m_data = req_data[w]; m_tag = w; m_ptr = w;
      if (!m_locked && req_lock[w]) begin
        m_locked = 1; m_owner = w;
      end else if (m_locked && !req_lock[w]) begin
        m_locked = 0;
      end
    end else if (!m_vld || mem_ready) begin
      m_vld = 0;
    end
  endtask

  // One clock: check ready mid-cycle, advance model at the edge, check registered outputs after it.
  task automatic tick();
    logic [N-1:0] exp_rdy;
    int w;
    #1;
    w = model_winner();
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    vectors++;
    if (req_ready !== exp_rdy) begin
      miscompares++;
      $display("FAIL ready: got %b expected %b at %0t", req_ready, exp_rdy, $time);
    end
    last_w = w;
    @(posedge clk);
    model_update(w);
    #1;
    vectors++;
    if (mem_valid !== m_vld) begin
      miscompares++;
      $display("FAIL mem_valid: got %b expected %b at %0t", mem_valid, m_vld, $time);
    end
    vectors++;
    if (mem_data !== m_data || mem_tag !== TW'(m_tag)) begin
      miscompares++;
      $display("FAIL mem_beat: got data %h tag %0d expected data %h tag %0d at %0t",
               mem_data, mem_tag, m_data, m_tag, $time);
    end
    vectors++;
    if (locked !== m_locked) begin
      miscompares++;
      $display("FAIL locked: got %b expected %b at %0t", locked, m_locked, $time);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_lock = '0; mem_ready = 1'b1;
    for (int i = 0; i < N; i++) req_data[i] = DW'(32'hA0 + i);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    req_valid = '1;
    reset = 1'b1;
    tick();
    tick();
    vectors++;
    if (mem_valid !== 1'b0 || mem_data !== '0 || mem_tag !== '0 || locked !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got vld %b data %h tag %0d locked %b expected all zero",
               mem_valid, mem_data, mem_tag, locked);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0001; req_data[0] = 32'h11;
    tick();
    req_valid = '0;
    vectors++;
    if (last_w !== 0 || mem_valid !== 1'b1 || mem_data !== 32'h11 || mem_tag !== 2'd0) begin
      miscompares++;
      $display("FAIL single: got win %0d vld %b data %h tag %0d expected win 0 vld 1 data 11 tag 0",
               last_w, mem_valid, mem_data, mem_tag);
    end
    tick();
  endtask

  task automatic test_fairness();
    do_reset();
    req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      tick();
      vectors++;
      if (mem_tag !== TW'(c % N)) begin
        miscompares++;
        $display("FAIL fairness: cycle %0d got tag %0d expected %0d", c, mem_tag, c % N);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 4'b0001; req_data[0] = 32'h55;
    tick();
    req_valid = 4'b0100; req_data[2] = 32'h77; mem_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      vectors++;
      if (last_w !== -1 || mem_data !== 32'h55 || mem_tag !== 2'd0 || mem_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL backpressure_hold: cycle %0d got win %0d data %h tag %0d expected none/55/0",
                 c, last_w, mem_data, mem_tag);
      end
    end
    mem_ready = 1'b1;
    tick();
    vectors++;
    if (last_w !== 2 || mem_data !== 32'h77 || mem_tag !== 2'd2) begin
      miscompares++;
      $display("FAIL backpressure_release: got win %0d data %h tag %0d expected 2/77/2",
               last_w, mem_data, mem_tag);
    end
  endtask

  task automatic test_lock_burst();
    bit exp_lk[3];
    exp_lk = '{1'b1, 1'b1, 1'b0};
    do_reset();
    req_valid = 4'b0001;
    tick();
    req_valid = '1;
    for (int b = 0; b < 3; b++) begin
      req_lock = (b < 2) ? 4'b0010 : 4'b0000;
      tick();
      vectors++;
      if (mem_tag !== 2'd1 || locked !== exp_lk[b]) begin
        miscompares++;
        $display("FAIL lock_burst: beat %0d got tag %0d locked %b expected 1/%b",
                 b, mem_tag, locked, exp_lk[b]);
      end
    end
    req_lock = '0;
    tick();
    vectors++;
    if (mem_tag !== 2'd2) begin
      miscompares++;
      $display("FAIL lock_after: got tag %0d expected 2", mem_tag);
    end
  endtask

  task automatic test_lock_idle();
    do_reset();
    req_valid = 4'b1000; req_lock = 4'b1000;
    tick();
    req_valid = 4'b0001; req_lock = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      vectors++;
      if (last_w !== -1 || locked !== 1'b1) begin
        miscompares++;
        $display("FAIL lock_idle: cycle %0d got win %0d locked %b expected none/1", c, last_w, locked);
      end
    end
    req_valid = 4'b1001;
    tick();
    req_valid = 4'b0001;
    tick();
    vectors++;
    if (last_w !== 0 || mem_tag !== 2'd0 || locked !== 1'b0) begin
      miscompares++;
      $display("FAIL lock_release: got win %0d tag %0d locked %b expected 0/0/0", last_w, mem_tag, locked);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 4'b0010; req_lock = 4'b0010; mem_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (mem_valid !== 1'b0 || locked !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got vld %b locked %b expected 0/0", mem_valid, locked);
    end
    req_valid = 4'b0101; req_lock = '0; mem_ready = 1'b1;
    tick();
    vectors++;
    if (last_w !== 0 || mem_tag !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_mid_grant: got win %0d tag %0d expected 0/0", last_w, mem_tag);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      req_valid = N'($urandom);
      req_lock  = N'($urandom) & N'($urandom);
      for (int i = 0; i < N; i++) req_data[i] = $urandom;
      mem_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 60) == 0);
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_lock_burst();
    test_lock_idle();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
